// File: rtl/flash_cmd_engine.sv
// flash_cmd_engine
// Parses the binary host command protocol arriving from the UART receiver,
// runs timed read/write bus cycles on the parallel NOR flash and streams read
// data or status/ack bytes back into the UART transmitter.
//
// Ports:
//   clk, nrst              48 MHz clock, asynchronous active-low reset
//   rx_data, rx_rdy        received byte and its one-cycle valid strobe
//   tx_data, tx_rdy        byte to send and its one-cycle start strobe
//   tx_busy                transmitter active
//   a                      flash word address (always the current address)
//   databus_o/_i/_oe       AD bus write data, read data, output enable
//   flash_nce/noe/nwe      flash control strobes, active low
//   flash_ready            flash RY/BY#, 1 = ready
//   busy                   engine is not idle
module flash_cmd_engine #(
    parameter int          RD_CYCLES = 6,
    parameter int          WR_CYCLES = 4,
    parameter int          BUSY_DLY  = 8,
    parameter logic [23:0] TIMEOUT   = 24'd4800000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic [7:0]  tx_data,
    output logic        tx_rdy,
    input  logic        tx_busy,
    output logic [25:0] a,
    output logic [15:0] databus_o,
    input  logic [15:0] databus_i,
    output logic        databus_oe,
    output logic        flash_nce,
    output logic        flash_noe,
    output logic        flash_nwe,
    input  logic        flash_ready,
    output logic        busy
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_GET_ARG    = 4'd1;
    localparam logic [3:0] S_RD_STROBE  = 4'd2;
    localparam logic [3:0] S_RD_SEND_LO = 4'd3;
    localparam logic [3:0] S_RD_SEND_HI = 4'd4;
    localparam logic [3:0] S_WR_SETUP   = 4'd5;
    localparam logic [3:0] S_WR_STROBE  = 4'd6;
    localparam logic [3:0] S_WR_HOLD    = 4'd7;
    localparam logic [3:0] S_WR_WAIT    = 4'd8;
    localparam logic [3:0] S_RESP       = 4'd9;
    localparam logic [3:0] S_TX_WAIT    = 4'd10;

    localparam logic [5:0]  RD_N  = 6'(RD_CYCLES);
    localparam logic [5:0]  WR_N  = 6'(WR_CYCLES);
    localparam logic [23:0] DLY_N = 24'(BUSY_DLY);

    logic [3:0]  r_state;
    logic [3:0]  r_ret;
    logic [7:0]  r_opcode;
    logic [2:0]  r_argcnt;
    logic [23:0] r_args;
    logic [25:0] r_addr;
    logic [8:0]  r_count;
    logic [5:0]  r_cnt;
    logic [23:0] r_tmo;
    logic [15:0] r_rdword;
    logic [7:0]  r_resp;
    logic        r_seen_busy;
    logic [7:0]  r_txd;
    logic        r_txrdy;
    logic [15:0] r_dbo;
    logic        r_dboe;
    logic        r_nce;
    logic        r_noe;
    logic        r_nwe;

    // The address output simply mirrors the address register, so it is valid
    // before every bus cycle and visible to the host board while idle.
    assign a          = r_addr;
    assign tx_data    = r_txd;
    assign tx_rdy     = r_txrdy;
    assign databus_o  = r_dbo;
    assign databus_oe = r_dboe;
    assign flash_nce  = r_nce;
    assign flash_noe  = r_noe;
    assign flash_nwe  = r_nwe;
    assign busy       = (r_state != S_IDLE);

    // Main engine. Argument bytes are shifted in from the top so that once the
    // last byte arrives, the earlier ones sit LSB-first in r_args. Every byte
    // sent goes through TX_WAIT, which requires tx_busy to rise and fall again
    // before continuing to r_ret; a stale tx_busy=0 never counts as done.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= S_IDLE;
            r_ret       <= S_IDLE;
            r_opcode    <= 8'h00;
            r_argcnt    <= 3'd0;
            r_args      <= 24'h0;
            r_addr      <= 26'h0;
            r_count     <= 9'd0;
            r_cnt       <= 6'd0;
            r_tmo       <= 24'h0;
            r_rdword    <= 16'h0;
            r_resp      <= 8'h00;
            r_seen_busy <= 1'b0;
            r_txd       <= 8'h00;
            r_txrdy     <= 1'b0;
            r_dbo       <= 16'h0;
            r_dboe      <= 1'b0;
            r_nce       <= 1'b1;
            r_noe       <= 1'b1;
            r_nwe       <= 1'b1;
        end else begin
            r_txrdy <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rx_rdy) begin
                        r_opcode <= rx_data;
                        case (rx_data)
                            8'h01: begin r_argcnt <= 3'd4; r_state <= S_GET_ARG; end
                            8'h02: begin r_argcnt <= 3'd1; r_state <= S_GET_ARG; end
                            8'h03: begin r_argcnt <= 3'd2; r_state <= S_GET_ARG; end
                            8'h04: begin r_resp <= {7'b0, flash_ready}; r_state <= S_RESP; end
                            default: begin r_resp <= 8'hEE; r_state <= S_RESP; end
                        endcase
                    end
                end
                S_GET_ARG: begin
                    if (rx_rdy) begin
                        r_args   <= {rx_data, r_args[23:8]};
                        r_argcnt <= r_argcnt - 3'd1;
                        if (r_argcnt == 3'd1) begin
                            case (r_opcode)
                                8'h01: begin
                                    r_addr  <= {rx_data[1:0], r_args};
                                    r_state <= S_IDLE;
                                end
                                8'h02: begin
                                    r_count <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                                    r_nce   <= 1'b0;
                                    r_noe   <= 1'b0;
                                    r_cnt   <= 6'd1;
                                    r_state <= S_RD_STROBE;
                                end
                                default: begin
                                    r_dbo   <= {rx_data, r_args[23:16]};
                                    r_nce   <= 1'b0;
                                    r_dboe  <= 1'b1;
                                    r_state <= S_WR_SETUP;
                                end
                            endcase
                        end
                    end
                end
                S_RD_STROBE: begin
                    if (r_cnt == RD_N) begin
                        r_rdword <= databus_i;
                        r_nce    <= 1'b1;
                        r_noe    <= 1'b1;
                        r_state  <= S_RD_SEND_LO;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                S_RD_SEND_LO: begin
                    if (!tx_busy) begin
                        r_txd       <= r_rdword[7:0];
                        r_txrdy     <= 1'b1;
                        r_seen_busy <= 1'b0;
                        r_ret       <= S_RD_SEND_HI;
                        r_state     <= S_TX_WAIT;
                    end
                end
                S_RD_SEND_HI: begin
                    if (!tx_busy) begin
                        r_txd       <= r_rdword[15:8];
                        r_txrdy     <= 1'b1;
                        r_seen_busy <= 1'b0;
                        r_addr      <= r_addr + 26'd1;
                        r_count     <= r_count - 9'd1;
                        r_ret       <= (r_count == 9'd1) ? S_IDLE : S_RD_STROBE;
                        r_state     <= S_TX_WAIT;
                    end
                end
                S_WR_SETUP: begin
                    r_nwe   <= 1'b0;
                    r_cnt   <= 6'd1;
                    r_state <= S_WR_STROBE;
                end
                S_WR_STROBE: begin
                    if (r_cnt == WR_N) begin
                        r_nwe   <= 1'b1;
                        r_state <= S_WR_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                S_WR_HOLD: begin
                    r_nce   <= 1'b1;
                    r_dboe  <= 1'b0;
                    r_tmo   <= 24'h0;
                    r_state <= S_WR_WAIT;
                end
                // flash_ready is meaningless for the first BUSY_DLY cycles
                // while the device has not yet pulled RY/BY# low.
                S_WR_WAIT: begin
                    if (r_tmo >= DLY_N && flash_ready) begin
                        r_resp  <= 8'hAA;
                        r_addr  <= r_addr + 26'd1;
                        r_state <= S_RESP;
                    end else if (r_tmo == TIMEOUT - 24'd1) begin
                        r_resp  <= 8'hEE;
                        r_addr  <= r_addr + 26'd1;
                        r_state <= S_RESP;
                    end else begin
                        r_tmo <= r_tmo + 24'd1;
                    end
                end
                S_RESP: begin
                    if (!tx_busy) begin
                        r_txd       <= r_resp;
                        r_txrdy     <= 1'b1;
                        r_seen_busy <= 1'b0;
                        r_ret       <= S_IDLE;
                        r_state     <= S_TX_WAIT;
                    end
                end
                S_TX_WAIT: begin
                    if (!r_seen_busy) begin
                        if (tx_busy) r_seen_busy <= 1'b1;
                    end else if (!tx_busy) begin
                        r_state <= r_ret;
                        if (r_ret == S_RD_STROBE) begin
                            r_nce <= 1'b0;
                            r_noe <= 1'b0;
                            r_cnt <= 6'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_cmd_engine.sv
// tb_flash_cmd_engine
// Directed bench for flash_cmd_engine with a small UART transmitter model and
// a four-word flash model (indexed by a[1:0]) with a controllable RY/BY#.
module tb_flash_cmd_engine;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_rdy = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_rdy;
    logic        tx_busy = 1'b0;
    logic [25:0] a;
    logic [15:0] databus_o;
    logic [15:0] databus_i;
    logic        databus_oe;
    logic        flash_nce;
    logic        flash_noe;
    logic        flash_nwe;
    logic        flash_ready = 1'b1;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  tx_q[$];
    int          tx_cyc = 0;
    int          uart_cnt = 0;
    int          txrdy_while_busy = 0;
    logic [15:0] mem[4];
    int          noe_run = 0, noe_pulses = 0, noe_badlen = 0;
    int          nwe_run = 0, nwe_pulses = 0, nwe_last_len = 0, nwe_rise_cyc = 0;
    logic [15:0] nwe_data = 16'h0;
    int          wr_bad = 0, inv_bad = 0;
    int          ready_cnt = 0, ready_low_len = 0;
    bit          ready_hold_low = 1'b0;
    logic        prev_nwe = 1'b1;
    int          cyc = 0;

    flash_cmd_engine #(
        .RD_CYCLES(6), .WR_CYCLES(4), .BUSY_DLY(8), .TIMEOUT(24'd1000)
    ) dut (
        .clk(clk), .nrst(nrst),
        .rx_data(rx_data), .rx_rdy(rx_rdy),
        .tx_data(tx_data), .tx_rdy(tx_rdy), .tx_busy(tx_busy),
        .a(a), .databus_o(databus_o), .databus_i(databus_i), .databus_oe(databus_oe),
        .flash_nce(flash_nce), .flash_noe(flash_noe), .flash_nwe(flash_nwe),
        .flash_ready(flash_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    assign databus_i = (!flash_nce && !flash_noe) ? mem[a[1:0]] : 16'h0000;

    // UART model, flash strobe monitors and RY/BY# model, all on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (tx_rdy) begin
            if (tx_busy) txrdy_while_busy++;
            tx_q.push_back(tx_data);
            tx_cyc   = cyc;
            uart_cnt = 4;
            tx_busy  = 1'b1;
        end else if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) tx_busy = 1'b0;
        end
        if (!flash_noe) noe_run++;
        else if (noe_run > 0) begin
            noe_pulses++;
            if (noe_run != 6) noe_badlen++;
            noe_run = 0;
        end
        if (!flash_nwe) begin
            nwe_run++;
            nwe_data = databus_o;
            if (databus_oe !== 1'b1 || flash_nce !== 1'b0) wr_bad++;
        end else if (nwe_run > 0) begin
            nwe_pulses++;
            nwe_last_len = nwe_run;
            nwe_run = 0;
        end
        if ((!flash_noe && !flash_nwe) || (databus_oe && !flash_noe)) inv_bad++;
        if (prev_nwe == 1'b0 && flash_nwe == 1'b1) begin
            ready_cnt    = ready_low_len;
            nwe_rise_cyc = cyc;
        end else if (ready_cnt > 0) begin
            ready_cnt--;
        end
        prev_nwe    = flash_nwe;
        flash_ready = !ready_hold_low && (ready_cnt == 0);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_rdy  = 1'b1;
        @(negedge clk);
        rx_rdy  = 1'b0;
    endtask

    task automatic set_addr(input logic [25:0] ad);
        send_byte(8'h01);
        send_byte(ad[7:0]);
        send_byte(ad[15:8]);
        send_byte(ad[23:16]);
        send_byte({6'b0, ad[25:24]});
        tick(2);
    endtask

    task automatic wait_tx(input int n, input int budget, output bit ok);
        int k = 0;
        while (tx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (tx_q.size() >= n);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int k = 0;
        while ((busy || tx_busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = !(busy || tx_busy);
    endtask

    task automatic clear_monitors();
        tx_q.delete();
        noe_pulses = 0; noe_badlen = 0;
        nwe_pulses = 0; nwe_last_len = 0; wr_bad = 0;
    endtask

    task automatic test_reset();
        tick(3);
        n_cmp++;
        if ({flash_nce, flash_noe, flash_nwe, databus_oe, tx_rdy, busy} !== 6'b111000) begin
            n_bad++;
            $display("[TB] FAIL reset_ctrl: got %b want 111000",
                     {flash_nce, flash_noe, flash_nwe, databus_oe, tx_rdy, busy});
        end
        n_cmp++;
        if (a !== 26'h0 || databus_o !== 16'h0 || tx_data !== 8'h0) begin
            n_bad++;
            $display("[TB] FAIL reset_data: got a=%h dbo=%h txd=%h want all 0", a, databus_o, tx_data);
        end
        nrst = 1'b1;
        tick(2);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_set_addr();
        send_byte(8'h01); send_byte(8'h34); send_byte(8'h12); send_byte(8'h05); send_byte(8'hFC);
        tick(3);
        n_cmp++;
        if (a !== 26'h0051234) begin
            n_bad++;
            $display("[TB] FAIL set_addr: got %h want 0051234", a);
        end
        n_cmp++;
        if (tx_q.size() != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL set_addr_quiet: got tx=%0d busy=%b want 0/0", tx_q.size(), busy);
        end
    endtask

    task automatic test_read();
        bit ok;
        logic [7:0] exp[4];
        exp[0] = 8'hEF; exp[1] = 8'hBE; exp[2] = 8'h34; exp[3] = 8'h12;
        set_addr(26'h0);
        clear_monitors();
        send_byte(8'h02); send_byte(8'h02);
        wait_tx(4, 400, ok);
        wait_idle(200, ok);
        n_cmp++;
        if (tx_q.size() != 4) begin
            n_bad++;
            $display("[TB] FAIL read_count: got %0d bytes want 4", tx_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (tx_q[i] !== exp[i]) begin
                    n_bad++;
                    $display("[TB] FAIL read_byte%0d: got %h want %h", i, tx_q[i], exp[i]);
                end
            end
        end
        n_cmp++;
        if (a !== 26'd2) begin
            n_bad++;
            $display("[TB] FAIL read_addr: got %h want 2", a);
        end
        n_cmp++;
        if (noe_pulses != 2 || noe_badlen != 0) begin
            n_bad++;
            $display("[TB] FAIL read_noe: got pulses=%0d badlen=%0d want 2/0", noe_pulses, noe_badlen);
        end
    endtask

    task automatic test_read_wrap();
        bit ok;
        set_addr(26'h3FFFFFF);
        clear_monitors();
        send_byte(8'h02); send_byte(8'h01);
        wait_tx(2, 200, ok);
        wait_idle(200, ok);
        n_cmp++;
        if (tx_q.size() != 2 || tx_q[0] !== 8'h5A || tx_q[1] !== 8'hC3) begin
            n_bad++;
            $display("[TB] FAIL wrap_data: got %0d bytes first=%h want 5A C3",
                     tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'h00);
        end
        n_cmp++;
        if (a !== 26'h0) begin
            n_bad++;
            $display("[TB] FAIL wrap_addr: got %h want 0", a);
        end
    endtask

    task automatic test_read_256();
        bit ok;
        int errs = 0;
        set_addr(26'h0);
        clear_monitors();
        send_byte(8'h02); send_byte(8'h00);
        wait_tx(512, 20000, ok);
        wait_idle(200, ok);
        n_cmp++;
        if (tx_q.size() != 512) begin
            n_bad++;
            $display("[TB] FAIL read256_count: got %0d bytes want 512", tx_q.size());
        end else begin
            for (int i = 0; i < 256; i++) begin
                if (tx_q[2*i] !== mem[i % 4][7:0] || tx_q[2*i+1] !== mem[i % 4][15:8]) errs++;
            end
            n_cmp++;
            if (errs != 0) begin
                n_bad++;
                $display("[TB] FAIL read256_data: got %0d bad words want 0", errs);
            end
        end
        n_cmp++;
        if (a !== 26'd256 || noe_pulses != 256) begin
            n_bad++;
            $display("[TB] FAIL read256_addr: got a=%h pulses=%0d want 100/256", a, noe_pulses);
        end
    endtask

    task automatic test_write();
        bit ok;
        logic [25:0] a0;
        a0 = a;
        clear_monitors();
        ready_low_len = 20;
        send_byte(8'h03); send_byte(8'hCD); send_byte(8'hAB);
        wait_tx(1, 500, ok);
        wait_idle(200, ok);
        n_cmp++;
        if (tx_q.size() != 1 || tx_q[0] !== 8'hAA) begin
            n_bad++;
            $display("[TB] FAIL write_ack: got %0d bytes first=%h want AA",
                     tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'h00);
        end
        n_cmp++;
        if (nwe_pulses != 1 || nwe_last_len != 4 || nwe_data !== 16'hABCD || wr_bad != 0) begin
            n_bad++;
            $display("[TB] FAIL write_pulse: got n=%0d len=%0d data=%h bad=%0d want 1/4/ABCD/0",
                     nwe_pulses, nwe_last_len, nwe_data, wr_bad);
        end
        n_cmp++;
        if (tx_cyc - nwe_rise_cyc < 20) begin
            n_bad++;
            $display("[TB] FAIL write_ready_wait: got %0d cycles want >=20", tx_cyc - nwe_rise_cyc);
        end
        n_cmp++;
        if (a !== a0 + 26'd1) begin
            n_bad++;
            $display("[TB] FAIL write_addr: got %h want %h", a, a0 + 26'd1);
        end
        ready_low_len = 0;
    endtask

    task automatic test_write_timeout();
        bit ok;
        logic [25:0] a0;
        int dt;
        a0 = a;
        clear_monitors();
        ready_hold_low = 1'b1;
        send_byte(8'h03); send_byte(8'hCD); send_byte(8'hAB);
        wait_tx(1, 2000, ok);
        dt = tx_cyc - nwe_rise_cyc;
        wait_idle(200, ok);
        n_cmp++;
        if (tx_q.size() != 1 || tx_q[0] !== 8'hEE) begin
            n_bad++;
            $display("[TB] FAIL timeout_resp: got %0d bytes first=%h want EE",
                     tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'h00);
        end
        n_cmp++;
        if (dt < 1000 || dt > 1010) begin
            n_bad++;
            $display("[TB] FAIL timeout_delay: got %0d cycles want 1000..1010", dt);
        end
        n_cmp++;
        if (busy !== 1'b0 || a !== a0 + 26'd1) begin
            n_bad++;
            $display("[TB] FAIL timeout_idle: got busy=%b a=%h want 0/%h", busy, a, a0 + 26'd1);
        end
        ready_hold_low = 1'b0;
        tick(2);
    endtask

    task automatic test_bad_opcode_status();
        bit ok;
        clear_monitors();
        send_byte(8'h7F);
        wait_tx(1, 100, ok);
        wait_idle(100, ok);
        send_byte(8'h04);
        wait_tx(2, 100, ok);
        wait_idle(100, ok);
        n_cmp++;
        if (tx_q.size() != 2 || tx_q[0] !== 8'hEE || tx_q[1] !== 8'h01) begin
            n_bad++;
            $display("[TB] FAIL opcode_status: got %0d bytes want EE 01", tx_q.size());
        end
        // A byte arriving while the status reply is in flight must be dropped
        clear_monitors();
        send_byte(8'h04);
        send_byte(8'h7F);
        tick(100);
        n_cmp++;
        if (tx_q.size() != 1 || tx_q[0] !== 8'h01) begin
            n_bad++;
            $display("[TB] FAIL drop_byte: got %0d bytes want 1 (01)", tx_q.size());
        end
    endtask

    task automatic test_reset_midcycle();
        bit ok;
        int k;
        set_addr(26'h5);
        clear_monitors();
        send_byte(8'h02); send_byte(8'h01);
        k = 0;
        while (flash_noe && k < 50) begin @(negedge clk); k++; end
        #2 nrst = 1'b0;
        #1;
        n_cmp++;
        if ({flash_nce, flash_noe, flash_nwe, databus_oe, busy} !== 5'b11100) begin
            n_bad++;
            $display("[TB] FAIL rst_read: got %b want 11100",
                     {flash_nce, flash_noe, flash_nwe, databus_oe, busy});
        end
        tick(2);
        nrst = 1'b1;
        tick(30);
        n_cmp++;
        if (tx_q.size() != 0 || a !== 26'h0) begin
            n_bad++;
            $display("[TB] FAIL rst_read_after: got tx=%0d a=%h want 0/0", tx_q.size(), a);
        end
        send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
        k = 0;
        while (flash_nwe && k < 50) begin @(negedge clk); k++; end
        #2 nrst = 1'b0;
        #1;
        n_cmp++;
        if ({flash_nce, flash_noe, flash_nwe, databus_oe, busy} !== 5'b11100) begin
            n_bad++;
            $display("[TB] FAIL rst_write: got %b want 11100",
                     {flash_nce, flash_noe, flash_nwe, databus_oe, busy});
        end
        tick(2);
        nrst = 1'b1;
        tick(30);
        n_cmp++;
        if (tx_q.size() != 0 || txrdy_while_busy != 0 || inv_bad != 0) begin
            n_bad++;
            $display("[TB] FAIL rst_write_after: got tx=%0d rdy_busy=%0d inv=%0d want 0/0/0",
                     tx_q.size(), txrdy_while_busy, inv_bad);
        end
        wait_idle(100, ok);
    endtask

    initial begin
        mem[0] = 16'hBEEF; mem[1] = 16'h1234; mem[2] = 16'h0F0F; mem[3] = 16'hC35A;
        test_reset();
        test_set_addr();
        test_read();
        test_read_wrap();
        test_read_256();
        test_write();
        test_write_timeout();
        test_bad_opcode_status();
        test_reset_midcycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/flash_cmd_engine.md
Name: flash_cmd_engine

Overview:
- Command engine between the host UART and the parallel NOR flash bus of the flash-programmer board.
- Consumes received UART bytes and parses a small binary command protocol.
- Runs timed flash read and write bus cycles, then streams results and acks back into the UART transmitter.
- Sits in the 48 MHz domain, directly downstream of the UART receiver and upstream of its transmitter and the flash pins.

Parameters:
RD_CYCLES, 6, cycles flash_noe is held low before the data sample (6 = 125 ns at 48 MHz); legal range 2..63.
WR_CYCLES, 4, cycles flash_nwe is held low per write; legal range 2..63.
BUSY_DLY, 8, cycles ignored after a write before flash_ready is sampled.
TIMEOUT, 24'd4800000, max cycles waiting for flash_ready (100 ms).

Ports:
clk  in  1  48 MHz system clock
nrst  in  1  asynchronous active-low reset
rx_data  in  8  received UART byte
rx_rdy  in  1  one-cycle strobe: rx_data valid
tx_data  out  8  byte to transmit
tx_rdy  out  1  one-cycle strobe: start transmit of tx_data
tx_busy  in  1  UART transmitter active
a  out  26  flash word address
databus_o  out  16  write data to the bidirectional AD bus buffers
databus_i  in  16  read data from the AD bus buffers
databus_oe  out  1  AD bus output enable
flash_nce  out  1  flash chip enable, active low
flash_noe  out  1  flash output enable, active low
flash_nwe  out  1  flash write enable, active low
flash_ready  in  1  flash RY/BY#, 1 = ready
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset, asynchronous on nrst low, applies immediately, including mid-cycle:
  - flash_nce, flash_noe and flash_nwe go to 1.
  - databus_oe=0, tx_rdy=0, tx_data=0, a=0, databus_o=0, busy=0.
  - State returns to IDLE and the address register clears.
- Protocol (first byte is the opcode, then argument bytes):
  - 0x01 SET_ADDR + 4 bytes, LSB first. addr = {b3[1:0],b2,b1,b0}; b3[7:2] ignored. No response.
  - 0x02 READ + count byte N (0 means 256). Reads N words from addr; each word is sent low byte then high byte. addr increments by 1 per word, wrapping 26'h3FFFFFF to 0.
  - 0x03 WRITE + 2 bytes data, LSB first. Performs one write cycle at addr, waits for ready, then responds 0xAA (ok) or 0xEE (timeout). addr increments on either response.
  - 0x04 STATUS. Responds {7'b0, flash_ready}.
  - Any other opcode: respond 0xEE, return to IDLE.
- Parsing:
  - There is no inter-byte timeout: a partial command waits indefinitely.
  - rx_rdy strobes are accepted only in IDLE and GET_ARG. Bytes arriving in any other state are dropped silently.
- States: IDLE, GET_ARG, RD_STROBE, RD_SEND_LO, RD_SEND_HI, WR_SETUP, WR_STROBE, WR_HOLD, WR_WAIT, RESP, TX_WAIT.
- Read cycle:
  - a is set and flash_nce=flash_noe=0 on entering RD_STROBE; databus_oe stays 0.
  - databus_i is captured on the RD_CYCLES-th cycle.
  - On exit flash_nce and flash_noe return to 1 for at least 1 cycle before the next word's strobe.
- Write cycle:
  - WR_SETUP (1 cycle): flash_nce=0, databus_oe=1, databus_o=data, a=addr.
  - WR_STROBE: flash_nwe=0 for WR_CYCLES cycles.
  - WR_HOLD (1 cycle): flash_nwe=1 while databus_oe and flash_nce are held.
  - All outputs are then released.
  - WR_WAIT counts BUSY_DLY cycles, then polls flash_ready. Timeout counts from WR_WAIT entry.
- TX handshake:
  - tx_rdy pulses for exactly 1 cycle, and only when tx_busy=0; tx_data is stable from the pulse onward.
  - The FSM then enters TX_WAIT: it waits for tx_busy=1, then tx_busy=0, before the next byte or state.
  - tx_busy already 0 is not taken as completion.
- Never: flash_noe=0 and flash_nwe=0 together; databus_oe=1 while flash_noe=0.

Test Plan:
- Reset, then 01 34 12 05 FC -> a latched 26'h0051234 (0xFC, b3[1:0]=0); no tx_rdy.
- Set addr 0, flash model holds 0xBEEF@0 and 0x1234@1, send 02 02 -> tx EF BE 34 12; a ends at 2; flash_noe low for exactly 6 cycles per word.
- Send 03 CD AB with flash_ready low for 20 cycles after nwe rise -> one nwe pulse of 4 cycles with databus_o=0xABCD and databus_oe=1 throughout; tx AA; a increments.
- Same write with flash_ready held low and TIMEOUT=1000 -> tx EE after 1000 cycles; FSM back in IDLE.
- Send 0x7F -> tx EE; then send 04 with flash_ready=1 -> tx 01.
- Assert nrst low during RD_STROBE and during WR_STROBE -> nce/noe/nwe=1 and databus_oe=0 in the same cycle; busy=0; tx_rdy never pulses.
